joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 clk  input  1  system clock, 40-50 MHz; all logic on its rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 joy1  input  12  player-1 buttons, active-high; bits {F,E,D,C,B,A,U,D,L,R} map to [11:0] as F..A=[9:4], U=[3], D=[2], L=[1], R=[0], [11:10] = S (start), L (select).
REQ-004 joy2  input  12  player-2 buttons, same layout as joy1.
REQ-005 JOY_CLK  input  1  shift clock from the receiver, asynchronous to clk.
REQ-006 JOY_LOAD  input  1  parallel-load strobe from the receiver, active-low, asynchronous to clk.
REQ-007 JOY_DATA  output  1  serial data to the receiver, active-low (0 = pressed).
REQ-008 frame_done  output  1  one-cycle pulse when bit 23 has been shifted out.
REQ-009 overrun  output  1  sticky; set when JOY_CLK edges exceed 24 in one frame.
REQ-010 link_idle  output  1  high while no JOY_LOAD falling edge has occurred for IDLE_CYC clocks.
REQ-011 Parameter IDLE_CYC, default 2_000_000, idle timeout in clk cycles.

Function
REQ-012 JOY_CLK and JOY_LOAD SHALL each pass through a 2-flop synchronizer, reset value 1, followed by a third flop for edge detection.
REQ-013 While synchronized JOY_LOAD = 0, the block SHALL reload shift_reg[23:0] = ~{joy2, joy1} every clk cycle and hold bit_cnt = 0.
REQ-014 The shift order SHALL be joy1[0] first, through joy1[11], then joy2[0] through joy2[11].
REQ-015 JOY_DATA SHALL be registered as shift_reg[0] while bit_cnt < 24, and as 1 when bit_cnt = 24.
REQ-016 On a synchronized JOY_CLK rising edge with JOY_LOAD = 1: shift_reg SHALL shift right with 1 filled at [23], and bit_cnt SHALL increment, saturating at 24.
REQ-017 The latency from a pin edge to the JOY_DATA update SHALL be exactly 4 clk cycles (2 sync + 1 detect + 1 output register).
REQ-018 A JOY_CLK edge that takes bit_cnt from 23 to 24 SHALL pulse frame_done for one cycle.
REQ-019 A JOY_CLK edge while bit_cnt = 24 SHALL set overrun; overrun SHALL clear only on the next JOY_LOAD falling edge.
REQ-020 If a JOY_LOAD low level and a JOY_CLK rising edge coincide in the same cycle, the load SHALL win: no shift, no count, no overrun.
REQ-021 JOY_LOAD asserted mid-frame SHALL abort the frame: reload, bit_cnt = 0, no frame_done.
REQ-022 Changes on joy1/joy2 after the JOY_LOAD rising edge SHALL NOT affect the frame in progress.
REQ-023 The idle counter (width clog2(IDLE_CYC+1)) SHALL clear on each JOY_LOAD falling edge, increment otherwise, and saturate at IDLE_CYC; link_idle = (counter == IDLE_CYC).

Reset
REQ-024 When resetn = 0 on a clk edge: shift_reg = all 1s, bit_cnt = 24, JOY_DATA = 1, frame_done = 0, overrun = 0, synchronizers = 1, idle counter = IDLE_CYC (link_idle = 1).
REQ-025 A reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; the first frame after reset SHALL begin only at a JOY_LOAD low level.

Structure
REQ-026 The frame length (24), bits per player (12), and bit-position constants for the R,L,D,U,A-F,S,Sel bits SHALL live in the shared package joy_pkg, which the receiver also uses.
REQ-027 One sub-module, sync_edge (2-flop synchronizer plus rising/falling edge outputs), SHALL be instantiated twice, once for JOY_CLK and once for JOY_LOAD.

Verification
REQ-028 joy1=12'h001, joy2=0, LOAD pulse, then 24 CLK edges -> the receiver sees bit0=0 and all other bits=1; frame_done pulses once after edge 24.
REQ-029 joy1=0, joy2=12'h800, full frame -> only serial bit 23 = 0; JOY_DATA = 1 after edge 24.
REQ-030 Full frame followed by 2 extra CLK edges -> JOY_DATA stays 1, overrun = 1; the next LOAD falling edge clears overrun.
REQ-031 LOAD after 10 CLK edges, joy1 changed to 12'hFFF -> the new frame starts at bit0 = 0 with the new data; no frame_done for the aborted frame.
REQ-032 CLK rising edge and LOAD low in the same synchronized cycle -> bit_cnt stays 0 and JOY_DATA = ~joy1[0].
REQ-033 IDLE_CYC=100, no LOAD for 100 cycles -> link_idle rises at cycle 100; the next LOAD falling edge drops it the following cycle; resetn low mid-frame -> JOY_DATA=1 and bit_cnt=24.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared DB15 joystick link definitions, used by both the transmitter and
// the receiver side.
//   FRAME_LEN        serial bits per frame (both players)
//   BITS_PER_PLAYER  button bits per player word
//   joy_bit_e        bit position of each button inside a player word
//   frame_word()     builds the active-low frame image from two player words
package joy_pkg;

    localparam int unsigned FRAME_LEN       = 24;
    localparam int unsigned BITS_PER_PLAYER = 12;

    typedef logic [BITS_PER_PLAYER-1:0] joy_word_t;
    typedef logic [FRAME_LEN-1:0]       frame_t;
    typedef logic [4:0]                 bit_cnt_t;

    // bit_cnt == CNT_FULL means the frame is complete (or none is active).
    localparam bit_cnt_t CNT_FULL = 5'd24;
    localparam bit_cnt_t CNT_LAST = 5'd23;

    typedef enum logic [3:0] {
        JOY_BIT_RIGHT  = 4'd0,
        JOY_BIT_LEFT   = 4'd1,
        JOY_BIT_DOWN   = 4'd2,
        JOY_BIT_UP     = 4'd3,
        JOY_BIT_A      = 4'd4,
        JOY_BIT_B      = 4'd5,
        JOY_BIT_C      = 4'd6,
        JOY_BIT_D      = 4'd7,
        JOY_BIT_E      = 4'd8,
        JOY_BIT_F      = 4'd9,
        JOY_BIT_SELECT = 4'd10,
        JOY_BIT_START  = 4'd11
    } joy_bit_e;

    // Player 1 occupies the low half so its bit 0 is shifted out first;
    // the line is active-low, hence the inversion.
    function automatic frame_t frame_word(input joy_word_t p1, input joy_word_t p2);
        return ~{p2, p1};
    endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// Link bundle between the joystick source and the DB15 serial transmitter.
//   joy1, joy2   player button words (active-high)
//   JOY_CLK      shift clock from the receiver (asynchronous)
//   JOY_LOAD     parallel-load strobe from the receiver (active-low, asynchronous)
//   JOY_DATA     serial data to the receiver (active-low)
//   frame_done   one-cycle pulse after the last frame bit is shifted
//   overrun      sticky: too many shift clocks in one frame
//   link_idle    no load strobe seen for the idle timeout
// modport master: the side feeding buttons and receiver pins (bench / board)
// modport slave : the transmitter itself
interface joy_db15_tx_if;
    import joy_pkg::*;

    joy_word_t joy1;
    joy_word_t joy2;
    logic      JOY_CLK;
    logic      JOY_LOAD;
    logic      JOY_DATA;
    logic      frame_done;
    logic      overrun;
    logic      link_idle;

    modport master (
        output joy1, joy2, JOY_CLK, JOY_LOAD,
        input  JOY_DATA, frame_done, overrun, link_idle
    );

    modport slave (
        input  joy1, joy2, JOY_CLK, JOY_LOAD,
        output JOY_DATA, frame_done, overrun, link_idle
    );

endinterface

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer followed by one history flop for edge detection.
//   clk     system clock
//   resetn  synchronous active-low reset (all flops reset to 1, so a line
//           idling high produces no edge after reset)
//   din     asynchronous input
//   level   synchronized level
//   rise    one-cycle pulse on a synchronized 0->1 transition
//   fall    one-cycle pulse on a synchronized 1->0 transition
module sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus the history flop used for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick serial transmitter. The receiver strobes JOY_LOAD low to
// capture both player words, then clocks 24 bits out on JOY_CLK rising
// edges, player 1 bit 0 first. Both receiver pins are asynchronous and are
// synchronized locally; pin edge to JOY_DATA update is 4 clk cycles.
//   clk       system clock (40-50 MHz)
//   resetn    synchronous active-low reset
//   link      joy_db15_tx_if.slave: joy1/joy2, JOY_CLK, JOY_LOAD in;
//             JOY_DATA, frame_done, overrun, link_idle out
//   IDLE_CYC  clk cycles without a load strobe before link_idle asserts
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int unsigned IDLE_CYC = 2_000_000
) (
    input  logic          clk,
    input  logic          resetn,
    joy_db15_tx_if.slave  link
);

    localparam int unsigned         IDLE_W   = $clog2(IDLE_CYC + 1);
    localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(IDLE_CYC);
    localparam logic [IDLE_W-1:0]   IDLE_ONE = IDLE_W'(1);

    // Synchronized pin views.
    logic clk_lvl_unused_s;
    logic clk_rise_s;
    logic clk_fall_unused_s;
    logic load_lvl_s;
    logic load_rise_unused_s;
    logic load_fall_s;

    // State registers.
    frame_t            shift_reg_r;
    bit_cnt_t          bit_cnt_r;
    logic              data_r;
    logic              frame_done_r;
    logic              overrun_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic              link_idle_r;

    // Next-state values.
    frame_t            shift_next_s;
    bit_cnt_t          cnt_next_s;
    logic              data_next_s;
    logic              frame_done_next_s;
    logic              overrun_next_s;
    logic [IDLE_W-1:0] idle_next_s;
    logic              link_idle_next_s;

    sync_edge u_sync_clk (
        .clk    (clk),
        .resetn (resetn),
        .din    (link.JOY_CLK),
        .level  (clk_lvl_unused_s),
        .rise   (clk_rise_s),
        .fall   (clk_fall_unused_s)
    );

    sync_edge u_sync_load (
        .clk    (clk),
        .resetn (resetn),
        .din    (link.JOY_LOAD),
        .level  (load_lvl_s),
        .rise   (load_rise_unused_s),
        .fall   (load_fall_s)
    );

    // Shift register, bit counter and frame status next-state logic.
    // A low load level always wins over a coincident shift clock edge.
    always_comb begin
        shift_next_s      = shift_reg_r;
        cnt_next_s        = bit_cnt_r;
        frame_done_next_s = 1'b0;
        overrun_next_s    = overrun_r;

        if (!load_lvl_s) begin
            shift_next_s = frame_word(link.joy1, link.joy2);
            cnt_next_s   = 5'd0;
        end else if (clk_rise_s) begin
            shift_next_s = {1'b1, shift_reg_r[FRAME_LEN-1:1]};
            if (bit_cnt_r == CNT_FULL) begin
                // Extra clock past the end of the frame: count stays saturated.
                overrun_next_s = 1'b1;
            end else begin
                cnt_next_s        = bit_cnt_r + 5'd1;
                frame_done_next_s = (bit_cnt_r == CNT_LAST);
            end
        end else begin
            shift_next_s = shift_reg_r;
        end

        // Only a fresh load strobe releases the sticky overrun flag.
        if (load_fall_s) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_next_s;
        end
    end

    // Serial output: idle-high once the frame is exhausted.
    always_comb begin
        if (bit_cnt_r < CNT_FULL) begin
            data_next_s = shift_reg_r[0];
        end else begin
            data_next_s = 1'b1;
        end
    end

    // Link idle timeout counter, saturating at IDLE_MAX.
    always_comb begin
        if (load_fall_s) begin
            idle_next_s = {IDLE_W{1'b0}};
        end else if (idle_cnt_r != IDLE_MAX) begin
            idle_next_s = idle_cnt_r + IDLE_ONE;
        end else begin
            idle_next_s = idle_cnt_r;
        end
        link_idle_next_s = (idle_next_s == IDLE_MAX);
    end

    // State and registered outputs; reset leaves no frame in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_reg_r  <= {FRAME_LEN{1'b1}};
            bit_cnt_r    <= CNT_FULL;
            data_r       <= 1'b1;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            idle_cnt_r   <= IDLE_MAX;
            link_idle_r  <= 1'b1;
        end else begin
            shift_reg_r  <= shift_next_s;
            bit_cnt_r    <= cnt_next_s;
            data_r       <= data_next_s;
            frame_done_r <= frame_done_next_s;
            overrun_r    <= overrun_next_s;
            idle_cnt_r   <= idle_next_s;
            link_idle_r  <= link_idle_next_s;
        end
    end

    assign link.JOY_DATA   = data_r;
    assign link.frame_done = frame_done_r;
    assign link.overrun    = overrun_r;
    assign link.link_idle  = link_idle_r;

endmodule

// File: tb/tb_joy_db15_tx.sv
`timescale 1ns/1ps
module tb_joy_db15_tx;
    import joy_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   fd_cnt = 0;

    joy_db15_tx_if jif ();

    joy_db15_tx #(.IDLE_CYC(100)) dut (
        .clk    (clk),
        .resetn (resetn),
        .link   (jif.slave)
    );

    always #10 clk = ~clk;

    // Count every cycle frame_done is high (a stretched pulse counts twice).
    always @(posedge clk) begin
        if (jif.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    // Reference: what the receiver should see, button by button, active-low.
    function automatic logic [23:0] model_frame(input logic [11:0] p1, input logic [11:0] p2);
        logic [23:0] f;
        for (int b = 0; b < 12; b++) begin
            f[b]      = (p1[b] == 1'b1) ? 1'b0 : 1'b1;
            f[12 + b] = (p2[b] == 1'b1) ? 1'b0 : 1'b1;
        end
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse();
        jif.JOY_LOAD = 1'b0;
        tick(6);
        jif.JOY_LOAD = 1'b1;
        tick(6);
    endtask

    task automatic clk_pulse();
        jif.JOY_CLK = 1'b1;
        tick(6);
        jif.JOY_CLK = 1'b0;
        tick(6);
    endtask

    // Receiver behaviour: sample the line, then clock; n clocks in total.
    task automatic capture(input int n, output logic [23:0] bits, output logic tail);
        bits = 24'hFFFFFF;
        for (int i = 0; i < n; i++) begin
            if (i < 24) bits[i] = jif.JOY_DATA;
            clk_pulse();
        end
        tail = jif.JOY_DATA;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            total++; if (jif.JOY_DATA !== 1'b1) begin bad++; $display("FAIL reset_data: got %b want 1", jif.JOY_DATA); end
            total++; if (jif.frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", jif.frame_done); end
            total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", jif.overrun); end
            total++; if (jif.link_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", jif.link_idle); end
            resetn = 1'b1;
            tick(2);
        end
    endtask

    task automatic test_fixed_frames();
        logic [11:0] p1 [2];
        logic [11:0] p2 [2];
        logic [23:0] got;
        logic        tail;
        int          fd0;
        p1[0] = 12'h001; p2[0] = 12'h000;
        p1[1] = 12'h000; p2[1] = 12'h800;
        for (int t = 0; t < 2; t++) begin
            jif.joy1 = p1[t];
            jif.joy2 = p2[t];
            load_pulse();
            fd0 = fd_cnt;
            capture(24, got, tail);
            total++; if (got !== model_frame(p1[t], p2[t])) begin bad++; $display("FAIL fixed_bits[%0d]: got %h want %h", t, got, model_frame(p1[t], p2[t])); end
            total++; if (tail !== 1'b1) begin bad++; $display("FAIL fixed_tail[%0d]: got %b want 1", t, tail); end
            total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL fixed_fd[%0d]: got %0d want 1", t, fd_cnt - fd0); end
            total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL fixed_ovr[%0d]: got %b want 0", t, jif.overrun); end
        end
    endtask

    task automatic test_random_frames();
        logic [11:0] j1, j2;
        logic [23:0] got;
        logic        tail;
        int          fd0;
        for (int t = 0; t < 6; t++) begin
            j1 = 12'($urandom);
            j2 = 12'($urandom);
            jif.joy1 = j1;
            jif.joy2 = j2;
            load_pulse();
            // Buttons keep moving during the frame; the frame must not notice.
            jif.joy1 = 12'($urandom);
            jif.joy2 = 12'($urandom);
            fd0 = fd_cnt;
            capture(24, got, tail);
            total++; if (got !== model_frame(j1, j2)) begin bad++; $display("FAIL rand_bits[%0d]: got %h want %h", t, got, model_frame(j1, j2)); end
            total++; if (tail !== 1'b1) begin bad++; $display("FAIL rand_tail[%0d]: got %b want 1", t, tail); end
            total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL rand_fd[%0d]: got %0d want 1", t, fd_cnt - fd0); end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] j1, j2;
        logic [23:0] got;
        logic        tail;
        int          fd0;
        j1 = 12'($urandom);
        j2 = 12'($urandom);
        jif.joy1 = j1;
        jif.joy2 = j2;
        load_pulse();
        fd0 = fd_cnt;
        capture(26, got, tail);
        total++; if (got !== model_frame(j1, j2)) begin bad++; $display("FAIL ovr_bits: got %h want %h", got, model_frame(j1, j2)); end
        total++; if (tail !== 1'b1) begin bad++; $display("FAIL ovr_tail: got %b want 1", tail); end
        total++; if (jif.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", jif.overrun); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL ovr_fd: got %0d want 1", fd_cnt - fd0); end
        load_pulse();
        total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", jif.overrun); end
    endtask

    task automatic test_abort();
        logic [11:0] j2;
        logic [23:0] got;
        logic        tail;
        int          fd0;
        jif.joy1 = 12'($urandom);
        jif.joy2 = 12'($urandom);
        load_pulse();
        fd0 = fd_cnt;
        capture(10, got, tail);
        j2 = 12'($urandom);
        jif.joy1 = 12'hFFF;
        jif.joy2 = j2;
        load_pulse();
        total++; if (fd_cnt !== fd0) begin bad++; $display("FAIL abort_nofd: got %0d want %0d", fd_cnt, fd0); end
        total++; if (jif.JOY_DATA !== 1'b0) begin bad++; $display("FAIL abort_bit0: got %b want 0", jif.JOY_DATA); end
        capture(24, got, tail);
        total++; if (got !== model_frame(12'hFFF, j2)) begin bad++; $display("FAIL abort_bits: got %h want %h", got, model_frame(12'hFFF, j2)); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL abort_fd: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_latency();
        jif.joy1 = 12'h001;
        jif.joy2 = 12'h000;
        load_pulse();
        total++; if (jif.JOY_DATA !== 1'b0) begin bad++; $display("FAIL lat_bit0: got %b want 0", jif.JOY_DATA); end
        jif.JOY_CLK = 1'b1;
        tick(3);
        total++; if (jif.JOY_DATA !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0 after 3 cycles", jif.JOY_DATA); end
        tick(1);
        total++; if (jif.JOY_DATA !== 1'b1) begin bad++; $display("FAIL lat_on_time: got %b want 1 after 4 cycles", jif.JOY_DATA); end
        jif.JOY_CLK = 1'b0;
        tick(6);
    endtask

    task automatic test_coincide();
        logic [11:0] j1, j2;
        logic [23:0] got;
        logic        tail;
        int          fd0;
        j1 = 12'($urandom);
        j1[0] = 1'b1;
        j1[1] = 1'b0;
        j2 = 12'($urandom);
        jif.joy1 = j1;
        jif.joy2 = j2;
        // Load low for one cycle, landing in the same synchronized cycle as a clock rise.
        jif.JOY_CLK  = 1'b1;
        jif.JOY_LOAD = 1'b0;
        tick(1);
        jif.JOY_LOAD = 1'b1;
        tick(6);
        total++; if (jif.JOY_DATA !== ~j1[0]) begin bad++; $display("FAIL coin_bit0: got %b want %b", jif.JOY_DATA, ~j1[0]); end
        jif.JOY_CLK = 1'b0;
        tick(6);
        fd0 = fd_cnt;
        capture(24, got, tail);
        total++; if (got !== model_frame(j1, j2)) begin bad++; $display("FAIL coin_bits: got %h want %h", got, model_frame(j1, j2)); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL coin_fd: got %0d want 1", fd_cnt - fd0); end
        total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL coin_ovr: got %b want 0", jif.overrun); end
    endtask

    task automatic test_idle();
        jif.JOY_LOAD = 1'b0;
        tick(102);
        total++; if (jif.link_idle !== 1'b0) begin bad++; $display("FAIL idle_before: got %b want 0", jif.link_idle); end
        tick(1);
        total++; if (jif.link_idle !== 1'b1) begin bad++; $display("FAIL idle_rise: got %b want 1", jif.link_idle); end
        jif.JOY_LOAD = 1'b1;
        tick(6);
        total++; if (jif.link_idle !== 1'b1) begin bad++; $display("FAIL idle_hold: got %b want 1", jif.link_idle); end
        jif.JOY_LOAD = 1'b0;
        tick(2);
        total++; if (jif.link_idle !== 1'b1) begin bad++; $display("FAIL idle_predrop: got %b want 1", jif.link_idle); end
        tick(1);
        total++; if (jif.link_idle !== 1'b0) begin bad++; $display("FAIL idle_drop: got %b want 0", jif.link_idle); end
        jif.JOY_LOAD = 1'b1;
        tick(6);
    endtask

    task automatic test_reset_midframe();
        logic [11:0] j1, j2;
        logic [23:0] got;
        logic        tail;
        int          fd0;
        jif.joy1 = 12'h000;
        jif.joy2 = 12'h000;
        load_pulse();
        capture(5, got, tail);
        fd0 = fd_cnt;
        resetn = 1'b0;
        tick(1);
        total++; if (jif.JOY_DATA !== 1'b1) begin bad++; $display("FAIL rst_mid_data: got %b want 1", jif.JOY_DATA); end
        resetn = 1'b1;
        tick(2);
        total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_ovr: got %b want 0", jif.overrun); end
        // Count must be saturated: one clock just overruns, line stays high.
        clk_pulse();
        total++; if (jif.JOY_DATA !== 1'b1) begin bad++; $display("FAIL rst_mid_idle_data: got %b want 1", jif.JOY_DATA); end
        total++; if (jif.overrun !== 1'b1) begin bad++; $display("FAIL rst_mid_cnt24: got %b want 1", jif.overrun); end
        total++; if (fd_cnt !== fd0) begin bad++; $display("FAIL rst_mid_nofd: got %0d want %0d", fd_cnt, fd0); end
        j1 = 12'($urandom);
        j2 = 12'($urandom);
        jif.joy1 = j1;
        jif.joy2 = j2;
        load_pulse();
        total++; if (jif.overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_ovr_clr: got %b want 0", jif.overrun); end
        capture(24, got, tail);
        total++; if (got !== model_frame(j1, j2)) begin bad++; $display("FAIL rst_mid_bits: got %h want %h", got, model_frame(j1, j2)); end
    endtask

    initial begin
        jif.joy1     = 12'h000;
        jif.joy2     = 12'h000;
        jif.JOY_CLK  = 1'b0;
        jif.JOY_LOAD = 1'b1;
        test_reset();
        test_fixed_frames();
        test_random_frames();
        test_overrun();
        test_abort();
        test_latency();
        test_coincide();
        test_idle();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
